// File: rtl/mmio_gpio_pkg.sv
// Shared constants for the memory-mapped GPIO bank: register word offsets,
// the default window base and a byte-enable expansion helper.
package mmio_gpio_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1013_0000;

  // Word offsets, i.e. byte offset >> 2
  localparam logic [5:0] OFF_OUT       = 6'h00;
  localparam logic [5:0] OFF_SET       = 6'h01;
  localparam logic [5:0] OFF_CLR       = 6'h02;
  localparam logic [5:0] OFF_TGL       = 6'h03;
  localparam logic [5:0] OFF_IN        = 6'h04;
  localparam logic [5:0] OFF_EDGE      = 6'h05;
  localparam logic [5:0] OFF_IRQ_EN    = 6'h06;
  localparam logic [5:0] OFF_BLINK_EN  = 6'h07;
  localparam logic [5:0] OFF_BLINK_DIV = 6'h08;

  typedef enum logic {
    SEL_RAM  = 1'b0,
    SEL_MMIO = 1'b1
  } rd_sel_e;

  // Expand 4 byte enables into a 32-bit bit mask
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchroniser for the GPIO inputs plus a rising-edge detector
// working on the synchronised value.
module gpio_in_sync #(
  parameter int NUM_CH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] gpio_i,
  output logic [NUM_CH-1:0] in_o,
  output logic [NUM_CH-1:0] rise_o
);

  logic [NUM_CH-1:0] s1_q;
  logic [NUM_CH-1:0] s2_q;
  logic [NUM_CH-1:0] prev_q;

  // Synchroniser chain and one-cycle history of the synchronised value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= gpio_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign in_o   = s2_q;
  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/mmio_gpio_bank.sv
// GPIO register bank sitting in front of a RAM. Accesses inside the 256-byte
// MMIO window are served locally; everything else passes through to the RAM.
// Read data of either source appears one cycle after the request.
module mmio_gpio_bank
  import mmio_gpio_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_CH     = 8,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      ram_req_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
  input  logic [NUM_CH-1:0]         gpio_i,
  output logic [NUM_CH-1:0]         gpio_o,
  output logic                      irq_o
);

  logic                  mmio_hit;
  logic                  wr;
  logic [5:0]            off;
  logic [DATA_WIDTH-1:0] bmask;
  logic [NUM_CH-1:0]     wmask;
  logic [NUM_CH-1:0]     wbits;
  logic [NUM_CH-1:0]     in_sync;
  logic [NUM_CH-1:0]     rise;
  logic                  unused_addr_lsb;

  logic [NUM_CH-1:0]     out_q, out_d;
  logic [NUM_CH-1:0]     edge_q, edge_d;
  logic [NUM_CH-1:0]     ien_q, ien_d;
  logic [NUM_CH-1:0]     ben_q, ben_d;
  logic [DATA_WIDTH-1:0] div_q, div_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [NUM_CH-1:0]     w1c;
  logic                  div_wr;
  logic [NUM_CH-1:0]     gpio_q;
  logic                  irq_q;

  logic [DATA_WIDTH-1:0] mrd;
  logic [DATA_WIDTH-1:0] mrd_q;
  rd_sel_e               sel_q;
  logic                  vld_q;

  assign mmio_hit        = (addr_i[ADDR_WIDTH-1:8] == MMIO_BASE[ADDR_WIDTH-1:8]);
  assign wr              = req_i & we_i & mmio_hit;
  assign off             = addr_i[7:2];
  assign bmask           = be_to_mask(be_i);
  assign wmask           = bmask[NUM_CH-1:0];
  assign wbits           = wdata_i[NUM_CH-1:0] & wmask;
  assign unused_addr_lsb = ^addr_i[1:0];

  assign ram_req_o   = req_i & ~mmio_hit;
  assign ram_addr_o  = addr_i;
  assign ram_we_o    = we_i;
  assign ram_be_o    = be_i;
  assign ram_wdata_o = wdata_i;

  gpio_in_sync #(.NUM_CH(NUM_CH)) u_in_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .gpio_i (gpio_i),
    .in_o   (in_sync),
    .rise_o (rise)
  );

  // Register write decode, edge capture and blink counter next state
  always_comb begin
    out_d  = out_q;
    ien_d  = ien_q;
    ben_d  = ben_q;
    div_d  = div_q;
    w1c    = '0;
    div_wr = 1'b0;
    if (wr) begin
      case (off)
        OFF_OUT:       out_d = (out_q & ~wmask) | wbits;
        OFF_SET:       out_d = out_q | wbits;
        OFF_CLR:       out_d = out_q & ~wbits;
        OFF_TGL:       out_d = out_q ^ wbits;
        OFF_EDGE:      w1c   = wbits;
        OFF_IRQ_EN:    ien_d = (ien_q & ~wmask) | wbits;
        OFF_BLINK_EN:  ben_d = (ben_q & ~wmask) | wbits;
        OFF_BLINK_DIV: begin
          div_d  = (div_q & ~bmask) | (wdata_i & bmask);
          div_wr = 1'b1;
        end
        default: ;
      endcase
    end
    // A new edge wins over a simultaneous clear of the same bit
    edge_d = (edge_q & ~w1c) | rise;

    cnt_d   = cnt_q + 32'd1;
    phase_d = phase_q;
    if (div_wr || (div_q == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == div_q - 32'd1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // MMIO read value selected from the current register contents
  always_comb begin
    mrd = '0;
    case (off)
      OFF_OUT:       mrd[NUM_CH-1:0] = out_q;
      OFF_IN:        mrd[NUM_CH-1:0] = in_sync;
      OFF_EDGE:      mrd[NUM_CH-1:0] = edge_q;
      OFF_IRQ_EN:    mrd[NUM_CH-1:0] = ien_q;
      OFF_BLINK_EN:  mrd[NUM_CH-1:0] = ben_q;
      OFF_BLINK_DIV: mrd             = div_q;
      default: ;
    endcase
  end

  // Register state, blink counter and registered pin/interrupt outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      edge_q  <= '0;
      ien_q   <= '0;
      ben_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      gpio_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      edge_q  <= edge_d;
      ien_q   <= ien_d;
      ben_q   <= ben_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      gpio_q  <= out_d & (~ben_d | {NUM_CH{phase_d}});
      irq_q   <= |(edge_d & ien_d);
    end
  end

  // Capture the read source and MMIO read value for the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      sel_q <= SEL_RAM;
      mrd_q <= '0;
    end else begin
      vld_q <= req_i;
      if (req_i) begin
        sel_q <= mmio_hit ? SEL_MMIO : SEL_RAM;
        mrd_q <= mrd;
      end
    end
  end

  assign rdata_o = !vld_q ? '0 : ((sel_q == SEL_MMIO) ? mrd_q : ram_rdata_i);
  assign gpio_o  = gpio_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Randomised and directed bench for mmio_gpio_bank with a behavioural model.
module tb_mmio_gpio_bank;

  localparam int          NCH  = 8;
  localparam logic [31:0] BASE = 32'h1013_0000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_i, we_i;
  logic [31:0]     addr_i, wdata_i;
  logic [3:0]      be_i;
  logic [31:0]     rdata_o;
  logic            ram_req_o, ram_we_o;
  logic [31:0]     ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [3:0]      ram_be_o;
  logic [NCH-1:0]  gpio_i, gpio_o;
  logic            irq_o;

  always #5 clk = ~clk;

  mmio_gpio_bank #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_CH     (NCH),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .ram_req_o   (ram_req_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .gpio_i      (gpio_i),
    .gpio_o      (gpio_o),
    .irq_o       (irq_o)
  );

  function automatic logic [31:0] ram_init(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Simple RAM with 1-cycle read latency
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= ram_init(i);
    end else if (ram_req_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o[7:2]];
      end
    end
  end

  // Reference model state
  logic [NCH-1:0] m_out, m_edge, m_ien, m_ben;
  logic [31:0]    m_div;
  longint         m_k;          // cycles since the blink sequence restarted
  logic [NCH-1:0] m_hist [3];   // gpio_i samples, [0] = most recent edge
  logic [31:0]    m_mem  [64];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = '0; m_edge = '0; m_ien = '0; m_ben = '0; m_div = '0; m_k = 0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = ram_init(i);
  endtask

  function automatic logic m_phase();
    if (m_div == 0) return 1'b1;
    return ((m_k / longint'(m_div)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] boff);
    case (boff & 8'hFC)
      8'h00:   return 32'(m_out);
      8'h10:   return 32'(m_hist[1]);   // input as sampled two edges ago
      8'h14:   return 32'(m_edge);
      8'h18:   return 32'(m_ien);
      8'h1C:   return 32'(m_ben);
      8'h20:   return m_div;
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock with the inputs currently applied; check outputs after it
  task automatic step(input bit chk_zero = 1'b0);
    bit             hit, rd, divw;
    logic [31:0]    rexp, ev;
    logic [NCH-1:0] wm, wb, rise;
    #1;
    hit = (addr_i[31:8] == BASE[31:8]);
    check("ram_req", 32'(ram_req_o), 32'(req_i && !hit));
    if (req_i) begin
      check("ram_addr", ram_addr_o, addr_i);
      check("ram_wdata", ram_wdata_o, wdata_i);
      check("ram_be_we", {27'd0, ram_we_o, ram_be_o}, {27'd0, we_i, be_i});
    end
    rd   = req_i && !we_i;
    rexp = hit ? m_read(addr_i[7:0]) : m_mem[addr_i[7:2]];
    for (int i = 0; i < NCH; i++) wm[i] = be_i[i/8];
    wb   = wdata_i[NCH-1:0] & wm;
    rise = m_hist[1] & ~m_hist[2];
    divw = 1'b0;
    if (req_i && we_i && hit) begin
      case (addr_i[7:0] & 8'hFC)
        8'h00: m_out = (m_out & ~wm) | wb;
        8'h04: m_out = m_out | wb;
        8'h08: m_out = m_out & ~wb;
        8'h0C: m_out = m_out ^ wb;
        8'h14: m_edge = m_edge & ~wb;
        8'h18: m_ien = (m_ien & ~wm) | wb;
        8'h1C: m_ben = (m_ben & ~wm) | wb;
        8'h20: begin
          divw = 1'b1;
          for (int b = 0; b < 4; b++) if (be_i[b]) m_div[8*b +: 8] = wdata_i[8*b +: 8];
        end
        default: ;
      endcase
    end else if (req_i && we_i) begin
      for (int b = 0; b < 4; b++)
        if (be_i[b]) m_mem[addr_i[7:2]][8*b +: 8] = wdata_i[8*b +: 8];
    end
    m_edge = m_edge | rise;
    if (divw || m_div == 0) m_k = 0;
    else m_k++;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = gpio_i;
    @(posedge clk);
    #1;
    ev = 32'(m_out & (~m_ben | {NCH{m_phase()}}));
    check("gpio_o", 32'(gpio_o), ev);
    check("irq_o", 32'(irq_o), 32'(|(m_edge & m_ien)));
    if (rd) check("rdata", rdata_o, rexp);
    else if (chk_zero) check("rdata_zero", rdata_o, 32'h0);
  endtask

  task automatic acc(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = d;
    step();
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    req_i = 1'b0; we_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic          prev;
    int            tog;
    logic [7:0]    offs [11];
    int            sel;
    logic [31:0]   a, d;

    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'hFC};
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0; gpio_i = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio", 32'(gpio_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    #2 rst_n = 1'b1;

    // Byte-enabled OUT write and read back
    acc(1, BASE + 32'h00, 4'b0001, 32'h0000_00A5);
    check("out_wr_gpio", 32'(gpio_o), 32'hA5);
    acc(0, BASE + 32'h00, 4'hF, 32'h0);
    check("out_rd", rdata_o, 32'h0000_00A5);

    // SET / CLR / TGL from zero
    acc(1, BASE + 32'h00, 4'hF, 32'h0);
    acc(1, BASE + 32'h04, 4'hF, 32'h0F);
    check("set", 32'(gpio_o), 32'h0F);
    acc(1, BASE + 32'h08, 4'hF, 32'h05);
    check("clr", 32'(gpio_o), 32'h0A);
    acc(1, BASE + 32'h0C, 4'hF, 32'h80);
    check("tgl", 32'(gpio_o), 32'h8A);
    acc(0, BASE + 32'h04, 4'hF, 32'h0);
    check("set_reads0", rdata_o, 32'h0);

    // Back-to-back RAM and MMIO traffic
    acc(1, 32'h0000_0040, 4'hF, 32'h1234_5678);
    acc(0, BASE + 32'h00, 4'hF, 32'h0);
    acc(0, 32'h0000_0040, 4'hF, 32'h0);
    check("ram_rd", rdata_o, 32'h1234_5678);
    acc(0, BASE + 32'h00, 4'hF, 32'h0);
    check("mmio_rd_after_ram", rdata_o, 32'h8A);
    acc(0, 32'h0000_0044, 4'hF, 32'h0);

    // Edge capture, interrupt, edge-vs-clear priority
    acc(1, BASE + 32'h18, 4'hF, 32'h08);
    gpio_i[3] = 1'b1; idle(3);
    gpio_i[3] = 1'b0; idle(3);
    check("irq_set", 32'(irq_o), 32'h1);
    acc(0, BASE + 32'h14, 4'hF, 32'h0);
    check("edge_rd", rdata_o, 32'h08);
    gpio_i[3] = 1'b1; idle(2);
    acc(1, BASE + 32'h14, 4'hF, 32'h08);
    check("edge_prio_irq", 32'(irq_o), 32'h1);
    acc(0, BASE + 32'h14, 4'hF, 32'h0);
    check("edge_prio_rd", rdata_o, 32'h08);
    acc(1, BASE + 32'h14, 4'hF, 32'h08);
    check("irq_clr", 32'(irq_o), 32'h0);
    gpio_i[3] = 1'b0; idle(3);

    // Blink on channel 0
    acc(1, BASE + 32'h00, 4'hF, 32'h01);
    acc(1, BASE + 32'h1C, 4'hF, 32'h01);
    acc(1, BASE + 32'h20, 4'hF, 32'd4);
    prev = gpio_o[0]; tog = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (gpio_o[0] != prev) tog++;
      prev = gpio_o[0];
    end
    check("blink_toggles", 32'(tog), 32'd4);
    acc(1, BASE + 32'h20, 4'hF, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("blink_hold", 32'(gpio_o[0]), 32'h1);
    end

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ NCH'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        a = BASE + 32'(offs[$urandom_range(0, 10)]);
        if ($urandom_range(0, 15) == 0) a = a + 32'h100;
        d = $urandom;
        if (a[7:0] == 8'h20) d = 32'($urandom_range(0, 5));
        acc(1'($urandom), a, 4'($urandom), d);
      end else if (sel < 7) begin
        a = {24'd0, 6'($urandom), 2'b00};
        acc(1'($urandom), a, 4'($urandom), $urandom);
      end else begin
        idle(1);
      end
    end

    // Reset in the middle of blinking and of a read
    gpio_i = '0;
    acc(1, BASE + 32'h00, 4'hF, 32'h01);
    acc(1, BASE + 32'h1C, 4'hF, 32'h01);
    acc(1, BASE + 32'h20, 4'hF, 32'd3);
    idle(5);
    req_i = 1'b1; we_i = 1'b0; addr_i = BASE + 32'h20; be_i = 4'hF;
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_i = 1'b0;
    #1;
    check("mid_rst_gpio", 32'(gpio_o), 32'h0);
    check("mid_rst_irq", 32'(irq_o), 32'h0);
    check("mid_rst_rdata", rdata_o, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    m_reset();
    step(1'b1);
    check("post_rst_rdata", rdata_o, 32'h0);
    acc(1, BASE + 32'h00, 4'hF, 32'h01);
    acc(1, BASE + 32'h1C, 4'hF, 32'h01);
    check("post_rst_phase", 32'(gpio_o[0]), 32'h1);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_gpio_bank.md
MMIO_GPIO_BANK -- requirements
Module: mmio_gpio_bank

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_WIDTH, 32, memory-side address width.
- DATA_WIDTH, 32, data width; fixed at 32.
- NUM_CH, 8, GPIO channel count, 1..32.
- MMIO_BASE, 'h1013_0000, base of a 256-byte register window aligned to 256 bytes.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  1  memory-side request from the AXI memory adapter.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  write enable.
- be_i  in  DATA_WIDTH/8  byte enables.
- wdata_i  in  DATA_WIDTH  write data.
- rdata_o  out  DATA_WIDTH  read data, returned 1 cycle after the request.
- ram_req_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o  out  (widths as the matching inputs)  RAM-side pass-through.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, 1-cycle latency.
- gpio_i  in  NUM_CH  asynchronous inputs.
- gpio_o  out  NUM_CH  outputs, e.g. LEDs.
- irq_o  out  1  level interrupt.

Function
REQ-004 SHALL decode an access as MMIO when addr_i[ADDR_WIDTH-1:8] == MMIO_BASE[ADDR_WIDTH-1:8]; all other accesses go to RAM.
REQ-005 SHALL drive ram_req_o = req_i & ~mmio_hit combinationally; the other ram_* outputs SHALL be straight copies of the matching inputs.
REQ-006 SHALL register the select and offset on every req_i, and next cycle SHALL drive rdata_o from either ram_rdata_i or the registered MMIO read value; read latency is 1 cycle in both cases.
REQ-007 SHALL implement these registers at word offsets of addr_i[7:2]; all are NUM_CH bits, zero-extended on read:
- 0x00 OUT: RW.
- 0x04 SET: write-1 sets OUT bits; reads 0.
- 0x08 CLR: write-1 clears OUT bits; reads 0.
- 0x0C TGL: write-1 inverts OUT bits; reads 0.
- 0x10 IN: RO, synchronised gpio_i.
- 0x14 EDGE: rising-edge sticky bits; write-1-to-clear.
- 0x18 IRQ_EN: RW.
- 0x1C BLINK_EN: RW.
- 0x20 BLINK_DIV: RW, 32 bits.
REQ-008 SHALL apply writes only to bytes with be_i set; bits at or above NUM_CH SHALL be ignored on write and read 0.
REQ-009 SHALL ignore writes to unmapped or RO offsets and return 0 on reads of them, with no error.
REQ-010 SHALL pass gpio_i through a 2-flop synchroniser; IN SHALL reflect a change 2 cycles after it.
REQ-011 SHALL set EDGE[i] when synchronised IN[i] goes 0->1 (previous 0, current 1).
REQ-012 SHALL give an edge the same cycle as a W1C of the same EDGE bit priority: the bit stays 1.
REQ-013 SHALL run a 32-bit blink counter while BLINK_DIV != 0:
- counter increments each cycle;
- on reaching BLINK_DIV-1 it wraps to 0 and the phase flop toggles.
REQ-014 SHALL hold counter=0 and phase=1 while BLINK_DIV == 0.
REQ-015 SHALL clear the counter and set phase=1 on any write to BLINK_DIV.
REQ-016 SHALL register gpio_o = OUT & (~BLINK_EN | {NUM_CH{phase}}); gpio_o follows a register write by 1 cycle.
REQ-017 SHALL register irq_o = |(EDGE & IRQ_EN); irq_o deasserts 1 cycle after the W1C write that clears the last enabled bit.

Reset
REQ-018 SHALL reset asynchronously to these values:
- OUT, EDGE, IRQ_EN, BLINK_EN, BLINK_DIV, counter = 0;
- phase = 1;
- synchronisers = 0;
- gpio_o = 0, irq_o = 0, rdata_o = 0, registered select = RAM.
REQ-019 SHALL drop a read in flight when reset asserts mid-access; rdata_o returns 0 after release.

Structure
REQ-020 SHALL place the register offset constants and the default MMIO_BASE in package mmio_gpio_pkg.
REQ-021 SHALL put the synchroniser and edge detect in sub-module gpio_in_sync, parametrised by NUM_CH.

Verification
REQ-022 SHALL cover these directed scenarios:
- Write 0x000000A5 to 0x1013_0000 with be=4'b0001, then read back -> gpio_o=0xA5 one cycle after the write; the read returns 0x000000A5 with 1-cycle latency.
- SET 0x0F, then CLR 0x05, then TGL 0x80, starting from OUT=0 -> OUT goes 0x0F, then 0x0A, then 0x8A.
- Interleave RAM write/read at 0x0000_0040 with MMIO reads in back-to-back cycles -> each rdata_o comes from the correct source one cycle later; ram_req_o stays low on MMIO cycles.
- Pulse gpio_i[3] high with IRQ_EN=0x08 -> EDGE=0x08 and irq_o=1; an edge in the same cycle as a W1C of 0x08 leaves EDGE=0x08; a later W1C deasserts irq_o.
- BLINK_DIV=4, BLINK_EN=0x01, OUT=0x01 -> gpio_o[0] toggles every 4 cycles; writing BLINK_DIV=0 holds gpio_o[0]=1.
- Assert rst_n low mid-blink and mid-read -> all outputs 0 immediately, phase=1.
